// File: rtl/longop_pkg.sv
// Shared types and constants for the long-operation scoreboard and its unit trackers.
package longop_pkg;

    typedef enum logic {
        UNIT_MCYCLE = 1'b0,
        UNIT_FPU    = 1'b1
    } unit_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_e;

    localparam logic [3:0] REG_PC = 4'd15;
    localparam int         NREG   = 16;

endpackage

// File: rtl/longop_scoreboard_unit_tracker.sv
// Per-unit lifecycle tracker: follows one outstanding long op from accept,
// through completion, to its register-file writeback grant.
module unit_tracker
    import longop_pkg::*;
(
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       accept,
    input  logic       done,
    input  logic       grant,
    input  logic [3:0] issueWA3,
    output state_e     state,
    output logic [3:0] destReg
);

    state_e nextState;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state   <= ST_IDLE;
            destReg <= 4'd0;
        end else begin
            state <= nextState;
            if (accept && state == ST_IDLE) begin
                destReg <= issueWA3;
            end
        end
    end

    // Done is only meaningful while BUSY; a stale or held Done elsewhere is ignored.
    always_comb begin
        nextState = state;
        unique case (state)
            ST_IDLE: if (accept) nextState = ST_BUSY;
            ST_BUSY: if (done)   nextState = ST_DONE;
            ST_DONE: if (grant)  nextState = ST_IDLE;
            default:             nextState = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/longop_scoreboard.sv
// Issue/writeback controller for the MCycle and FPU long-latency units:
// tracks pending destinations, stalls dependents, arbitrates the shared write port.
module longop_scoreboard #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              IssueValid,
    input  logic              IssueUnit,
    input  logic [3:0]        IssueWA3,
    input  logic [3:0]        RA1E,
    input  logic [3:0]        RA2E,
    input  logic [3:0]        WA3E,
    input  logic              UseRA1E,
    input  logic              UseRA2E,
    input  logic              RegWriteE,
    input  logic              FlushE,
    input  logic              MCycleDone,
    input  logic              FPUDone,
    input  logic [DATA_W-1:0] MCycleResult,
    input  logic [DATA_W-1:0] FPUResult,
    input  logic              RegWriteW,
    output logic              MStart,
    output logic              FPUStart,
    output logic              MCycleAck,
    output logic              FPUAck,
    output logic              ScoreStall,
    output logic              WBStall,
    output logic              LongWE,
    output logic [3:0]        LongWA3,
    output logic [DATA_W-1:0] LongWD,
    output logic              MCycleBusy,
    output logic              FPUBusy,
    output logic              IllegalWA
);

    import longop_pkg::*;

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pendingNext;
    unit_e           lastGrant;
    state_e          mState;
    state_e          fState;
    logic [3:0]      mDest;
    logic [3:0]      fDest;
    logic            conflict;
    logic            structural;
    logic            targetIdle;
    logic            accept;
    logic            mDone;
    logic            fDone;
    logic            grantM;
    logic            grantF;

    unit_tracker uMCycle (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .accept   (MStart),
        .done     (MCycleDone),
        .grant    (grantM),
        .issueWA3 (IssueWA3),
        .state    (mState),
        .destReg  (mDest)
    );

    unit_tracker uFpu (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .accept   (FPUStart),
        .done     (FPUDone),
        .grant    (grantF),
        .issueWA3 (IssueWA3),
        .state    (fState),
        .destReg  (fDest)
    );

    // Hazards look only at registered Pending, so a result being written this
    // cycle still blocks its dependents until the following cycle.
    always_comb begin
        conflict   = (UseRA1E   & pending[RA1E])
                   | (UseRA2E   & pending[RA2E])
                   | (RegWriteE & pending[WA3E])
                   | (IssueValid & pending[IssueWA3]);
        targetIdle = (IssueUnit == UNIT_FPU) ? (fState == ST_IDLE) : (mState == ST_IDLE);
        structural = IssueValid & ~targetIdle;
        ScoreStall = (conflict | structural) & ~FlushE;
        IllegalWA  = IssueValid & (IssueWA3 == REG_PC) & ~FlushE;
        accept     = IssueValid & ~ScoreStall & ~FlushE & ~IllegalWA;
        MStart     = accept & (IssueUnit == UNIT_MCYCLE);
        FPUStart   = accept & (IssueUnit == UNIT_FPU);
        MCycleBusy = (mState != ST_IDLE);
        FPUBusy    = (fState != ST_IDLE);
    end

    // Round-robin on a tie: the unit that did not win last time goes first.
    always_comb begin
        mDone     = (mState == ST_DONE);
        fDone     = (fState == ST_DONE);
        grantM    = mDone & (~fDone | (lastGrant == UNIT_FPU));
        grantF    = fDone & (~mDone | (lastGrant == UNIT_MCYCLE));
        MCycleAck = grantM;
        FPUAck    = grantF;
        LongWE    = grantM | grantF;
        LongWA3   = 4'd0;
        LongWD    = '0;
        if (grantM) begin
            LongWA3 = mDest;
            LongWD  = MCycleResult;
        end else if (grantF) begin
            LongWA3 = fDest;
            LongWD  = FPUResult;
        end
        WBStall = LongWE & RegWriteW;
    end

    always_comb begin
        pendingNext = pending;
        if (grantM) pendingNext[mDest] = 1'b0;
        if (grantF) pendingNext[fDest] = 1'b0;
        if (accept) pendingNext[IssueWA3] = 1'b1;
        pendingNext[REG_PC] = 1'b0;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            pending   <= '0;
            lastGrant <= UNIT_FPU;
        end else begin
            pending <= pendingNext;
            if (grantM) begin
                lastGrant <= UNIT_MCYCLE;
            end else if (grantF) begin
                lastGrant <= UNIT_FPU;
            end
        end
    end

endmodule
